// File: rtl/sonar_ping_gen.sv
// Ultrasonic ping engine: complementary 40 kHz burst, ring-down blanking, then
// echo time-of-flight measurement in clocks of the PLL output clock.
module sonar_ping_gen #(
   parameter int HALF_PERIOD  = 405,
   parameter int BURST_CYCLES = 8,
   parameter int BLANK_CLKS   = 3240,
   parameter int LISTEN_CLKS  = 60000,
   parameter int TOF_W        = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_lock,
   input  logic             start,
   input  logic             echo,
   output logic             tx_p,
   output logic             tx_n,
   output logic             busy,
   output logic [TOF_W-1:0] tof,
   output logic             tof_valid,
   output logic             timeout
);

   localparam int HALF_W    = $clog2(HALF_PERIOD);
   localparam int HIDX_W    = $clog2(2 * BURST_CYCLES);
   localparam int PHASE_MAX = (BLANK_CLKS > LISTEN_CLKS) ? BLANK_CLKS : LISTEN_CLKS;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

   localparam logic [HALF_W-1:0]  HALF_LAST   = HALF_W'(HALF_PERIOD - 1);
   localparam logic [HIDX_W-1:0]  HIDX_LAST   = HIDX_W'(2 * BURST_CYCLES - 1);
   localparam logic [PHASE_W-1:0] BLANK_LAST  = PHASE_W'(BLANK_CLKS - 1);
   localparam logic [PHASE_W-1:0] LISTEN_LAST = PHASE_W'(LISTEN_CLKS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BURST  = 2'd1;
   localparam logic [1:0] S_BLANK  = 2'd2;
   localparam logic [1:0] S_LISTEN = 2'd3;

   logic [1:0]         state;
   logic [HALF_W-1:0]  half_cnt;
   logic [HIDX_W-1:0]  half_idx;
   logic [PHASE_W-1:0] phase_cnt;
   logic [TOF_W-1:0]   tof_cnt;
   logic               echo_s1;
   logic               echo_s2;
   logic               echo_h;
   logic               echo_rise;

   // echo is fully asynchronous: two sync stages, then a history flop for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_s1 <= 1'b0;
         echo_s2 <= 1'b0;
         echo_h  <= 1'b0;
      end else begin
         echo_s1 <= echo;
         echo_s2 <= echo_s1;
         echo_h  <= echo_s2;
      end
   end

   assign echo_rise = echo_s2 & ~echo_h;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         half_cnt  <= '0;
         half_idx  <= '0;
         phase_cnt <= '0;
         tof_cnt   <= '0;
         tx_p      <= 1'b0;
         tx_n      <= 1'b0;
         busy      <= 1'b0;
         tof       <= '0;
         tof_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         tof_valid <= 1'b0;
         timeout   <= 1'b0;
         if (tof_cnt != '1)
            tof_cnt <= tof_cnt + TOF_W'(1);

         if (!pll_lock) begin
            state <= S_IDLE;
            tx_p  <= 1'b0;
            tx_n  <= 1'b0;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state    <= S_BURST;
                     busy     <= 1'b1;
                     tx_p     <= 1'b1;
                     tx_n     <= 1'b0;
                     half_cnt <= '0;
                     half_idx <= '0;
                     tof_cnt  <= '0;
                  end
               end
               S_BURST: begin
                  if (half_cnt == HALF_LAST) begin
                     half_cnt <= '0;
                     if (half_idx == HIDX_LAST) begin
                        state     <= S_BLANK;
                        phase_cnt <= '0;
                        tx_p      <= 1'b0;
                        tx_n      <= 1'b0;
                     end else begin
                        // next half index is even exactly when the current one is odd
                        half_idx <= half_idx + HIDX_W'(1);
                        tx_p     <= half_idx[0];
                        tx_n     <= ~half_idx[0];
                     end
                  end else begin
                     half_cnt <= half_cnt + HALF_W'(1);
                  end
               end
               S_BLANK: begin
                  if (phase_cnt == BLANK_LAST) begin
                     state     <= S_LISTEN;
                     phase_cnt <= '0;
                  end else begin
                     phase_cnt <= phase_cnt + PHASE_W'(1);
                  end
               end
               S_LISTEN: begin
                  if (echo_rise) begin
                     tof       <= tof_cnt;
                     tof_valid <= 1'b1;
                     state     <= S_IDLE;
                     busy      <= 1'b0;
                  end else if (phase_cnt == LISTEN_LAST) begin
                     timeout <= 1'b1;
                     state   <= S_IDLE;
                     busy    <= 1'b0;
                  end else begin
                     phase_cnt <= phase_cnt + PHASE_W'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sonar_ping_gen.sv
// Self-checking bench for sonar_ping_gen: randomized pings checked cycle by cycle
// against a timeline model derived from the burst/blank/listen durations.
module tb_sonar_ping_gen;

   localparam int HP = 4;
   localparam int BC = 2;
   localparam int BL = 10;
   localparam int LS = 50;
   localparam int TW = 8;

   localparam int BURST_LEN    = 2 * BC * HP;
   localparam int LISTEN_START = BURST_LEN + BL;
   localparam int LISTEN_END   = LISTEN_START + LS - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          pll_lock;
   logic          start;
   logic          echo;
   logic          tx_p;
   logic          tx_n;
   logic          busy;
   logic [TW-1:0] tof;
   logic          tof_valid;
   logic          timeout;

   int            checks   = 0;
   int            failures = 0;
   logic [TW-1:0] tof_exp  = '0;

   sonar_ping_gen #(
      .HALF_PERIOD (HP),
      .BURST_CYCLES(BC),
      .BLANK_CLKS  (BL),
      .LISTEN_CLKS (LS),
      .TOF_W       (TW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pll_lock (pll_lock),
      .start    (start),
      .echo     (echo),
      .tx_p     (tx_p),
      .tx_n     (tx_n),
      .busy     (busy),
      .tof      (tof),
      .tof_valid(tof_valid),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   // e = cycle (relative to first burst cycle) on which the synchronized echo edge lands
   function automatic bit echo_counts(input int e);
      return (e >= LISTEN_START) && (e <= LISTEN_END);
   endfunction

   function automatic int done_rel(input int e);
      return echo_counts(e) ? e + 1 : LISTEN_END + 1;
   endfunction

   // expected {tx_p, tx_n, busy, tof_valid, timeout} on cycle rel of a ping
   function automatic logic [4:0] model(input int rel, input int e);
      logic in_burst;
      logic even_h;
      int   d;
      in_burst = (rel >= 0) && (rel < BURST_LEN);
      even_h   = ((rel / HP) % 2) == 0;
      d        = done_rel(e);
      return {in_burst & even_h, in_burst & ~even_h, (rel >= 0) && (rel < d),
              (rel == d) && echo_counts(e), (rel == d) && !echo_counts(e)};
   endfunction

   task automatic test_reset();
      rst = 1'b1; pll_lock = 1'b1; start = 1'b0; echo = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({tx_p, tx_n, busy, tof_valid, timeout} !== 5'b0 || tof !== '0) begin
         failures++;
         $display("FAIL reset_hold got=%b tof=%0d want=00000 tof=0",
                  {tx_p, tx_n, busy, tof_valid, timeout}, tof);
      end
      rst = 1'b0;
      start = 1'b1;
      pll_lock = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_start_no_lock busy got=%b want=0", busy);
      end
      start = 1'b0;
      pll_lock = 1'b1;
      tof_exp = '0;
   endtask

   task automatic test_pings(input int trials);
      for (int t = 0; t < trials; t++) begin
         int          e;
         int          d;
         int          gap;
         logic [31:0] noise;
         logic [4:0]  exp_o;
         logic [TW-1:0] exp_tof;
         case (t)
            0: e = LISTEN_START + 14;
            1: e = -1;
            2: e = LISTEN_END;
            3: e = LISTEN_START - 1;
            default: e = ($urandom_range(0, 3) == 0) ? -1
                          : int'($urandom_range(LISTEN_START, LISTEN_END));
         endcase
         noise = (t == 0 || t == 2) ? 32'd0 : $urandom;
         gap   = (t % 3 == 1) ? 0 : int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            start = 1'b0; echo = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || tx_p !== 1'b0 || tx_n !== 1'b0) begin
               failures++;
               $display("FAIL idle_gap trial=%0d busy/tx got=%b%b%b want=000", t, busy, tx_p, tx_n);
            end
         end
         start = 1'b1; echo = 1'b0;
         d = done_rel(e);
         for (int rel = 0; rel <= d; rel++) begin
            @(posedge clk); #1;
            exp_o   = model(rel, e);
            exp_tof = (rel == d && echo_counts(e)) ? e[TW-1:0] : tof_exp;
            checks++;
            if ({tx_p, tx_n, busy, tof_valid, timeout} !== exp_o) begin
               failures++;
               $display("FAIL ping_outputs trial=%0d rel=%0d e=%0d got=%b want=%b",
                        t, rel, e, {tx_p, tx_n, busy, tof_valid, timeout}, exp_o);
            end
            checks++;
            if (tof !== exp_tof) begin
               failures++;
               $display("FAIL ping_tof trial=%0d rel=%0d got=%0d want=%0d", t, rel, tof, exp_tof);
            end
            start = (rel < d) ? 1'($urandom_range(0, 1)) : 1'b0;
            echo  = (rel <= 20 && noise[rel]) || (e >= 0 && rel >= e - 2 && rel <= e + 1);
         end
         if (echo_counts(e)) tof_exp = e[TW-1:0];
      end
      start = 1'b0; echo = 1'b0;
   endtask

   task automatic test_lock_drop(input int trials);
      for (int t = 0; t < trials; t++) begin
         int         d;
         logic [4:0] exp_o;
         d = (t == 0) ? 5 : int'($urandom_range(1, 70));
         start = 1'b1; echo = 1'b0; pll_lock = 1'b1;
         for (int rel = 0; rel <= d + 5; rel++) begin
            @(posedge clk); #1;
            exp_o = (rel <= d) ? model(rel, -1) : 5'b0;
            checks++;
            if ({tx_p, tx_n, busy, tof_valid, timeout} !== exp_o) begin
               failures++;
               $display("FAIL lock_drop trial=%0d drop=%0d rel=%0d got=%b want=%b",
                        t, d, rel, {tx_p, tx_n, busy, tof_valid, timeout}, exp_o);
            end
            checks++;
            if (tof !== tof_exp) begin
               failures++;
               $display("FAIL lock_drop_tof trial=%0d rel=%0d got=%0d want=%0d", t, rel, tof, tof_exp);
            end
            start    = (rel >= d);
            pll_lock = (rel < d);
         end
         start = 1'b0; pll_lock = 1'b1;
      end
   endtask

   task automatic test_mid_reset();
      int k;
      k = $urandom_range(2, 14);
      start = 1'b1; echo = 1'b0; pll_lock = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (k) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({tx_p, tx_n, busy, tof_valid, timeout} !== 5'b0 || tof !== '0) begin
         failures++;
         $display("FAIL mid_reset k=%0d got=%b tof=%0d want=00000 tof=0",
                  k, {tx_p, tx_n, busy, tof_valid, timeout}, tof);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      tof_exp = '0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || tof !== '0) begin
         failures++;
         $display("FAIL mid_reset_release busy=%b tof=%0d want busy=0 tof=0", busy, tof);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_pings(14);
      test_lock_drop(4);
      test_mid_reset();
      test_pings(6);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
